// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Contents:
//   arb_state_e  - bus ownership state (IDLE, LOCK0, LOCK1)
//   PORT0/PORT1  - port index constants (0 = core, 1 = DMA/loader)
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port
// synchronous RAM.
// Per requester n (0 = core, 1 = DMA/loader):
//   req_n, lock_n, we_n, addr_n, wdata_n  -> arbiter
//   gnt_n, rvalid_n, rdata_n              <- arbiter
// Memory side:
//   mem_addr, mem_wr_data, mem_wr_enable  <- arbiter
//   mem_rd_data                           -> arbiter (one cycle after mem_addr)
// Modports: slave = arbiter view, master = requester/memory view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              req_0;
    logic              lock_0;
    logic              we_0;
    logic [ADDR_W-1:0] addr_0;
    logic [DATA_W-1:0] wdata_0;
    logic              gnt_0;
    logic              rvalid_0;
    logic [DATA_W-1:0] rdata_0;

    logic              req_1;
    logic              lock_1;
    logic              we_1;
    logic [ADDR_W-1:0] addr_1;
    logic [DATA_W-1:0] wdata_1;
    logic              gnt_1;
    logic              rvalid_1;
    logic [DATA_W-1:0] rdata_1;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_enable;
    logic [DATA_W-1:0] mem_rd_data;

    modport slave (
        input  req_0, lock_0, we_0, addr_0, wdata_0,
        output gnt_0, rvalid_0, rdata_0,
        input  req_1, lock_1, we_1, addr_1, wdata_1,
        output gnt_1, rvalid_1, rdata_1,
        output mem_addr, mem_wr_data, mem_wr_enable,
        input  mem_rd_data
    );

    modport master (
        output req_0, lock_0, we_0, addr_0, wdata_0,
        input  gnt_0, rvalid_0, rdata_0,
        output req_1, lock_1, we_1, addr_1, wdata_1,
        input  gnt_1, rvalid_1, rdata_1,
        input  mem_addr, mem_wr_data, mem_wr_enable,
        output mem_rd_data
    );

endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-input round-robin picker used when nobody owns the bus.
// Ports:
//   req_i         - request vector, bit n = port n
//   last_served_i - port granted most recently
//   valid_o       - at least one request present
//   sel_o         - chosen port (the one not served last on a tie)
module arb_rr2 (
    input  logic [1:0] req_i,
    input  logic       last_served_i,
    output logic       valid_o,
    output logic       sel_o
);
    import mem_arbiter_pkg::*;

    always_comb begin
        valid_o = |req_i;
        sel_o   = PORT0;
        case (req_i)
            2'b10:   sel_o = PORT1;
            2'b11:   sel_o = ~last_served_i;
            default: sel_o = PORT0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// One access is accepted per cycle with zero-cycle grant latency; a port may
// hold the bus across accesses with lock_n, bounded by MAX_LOCK consecutive
// locked grants while the other port waits.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   bus        - mem_arbiter_if.slave: requester handshakes and memory bus
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 7
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    import mem_arbiter_pkg::*;

    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        rvalid_q, rvalid_d;

    logic [1:0]        req, lock, we, gnt;
    logic              locked, owner, other, force_ho;
    logic              rr_valid, rr_sel;
    logic              win_valid, win_sel;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    assign req  = {bus.req_1,  bus.req_0};
    assign lock = {bus.lock_1, bus.lock_0};
    assign we   = {bus.we_1,   bus.we_0};

    assign locked = (state_q != ST_IDLE);
    assign owner  = (state_q == ST_LOCK1) ? PORT1 : PORT0;
    assign other  = ~owner;
    // Starvation guard: the waiting port takes the bus once the owner has
    // used up its locked-grant budget.
    assign force_ho = locked && req[other] && (cnt_q == MAX_LOCK_C);

    arb_rr2 u_rr (
        .req_i        (req),
        .last_served_i(last_q),
        .valid_o      (rr_valid),
        .sel_o        (rr_sel)
    );

    // Winner selection; an owner that stops requesting keeps the bus idle.
    always_comb begin
        win_valid = 1'b0;
        win_sel   = PORT0;
        if (!reset) begin
            if (locked) begin
                if (force_ho) begin
                    win_valid = 1'b1;
                    win_sel   = other;
                end else if (req[owner]) begin
                    win_valid = 1'b1;
                    win_sel   = owner;
                end
            end else begin
                win_valid = rr_valid;
                win_sel   = rr_sel;
            end
        end
    end

    assign win_addr  = win_sel ? bus.addr_1  : bus.addr_0;
    assign win_wdata = win_sel ? bus.wdata_1 : bus.wdata_0;
    assign gnt       = {win_valid & win_sel, win_valid & ~win_sel};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            last_q   <= PORT1;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Next-state
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rvalid_d = gnt & ~we;
        if (win_valid) begin
            state_d = lock[win_sel] ? (win_sel ? ST_LOCK1 : ST_LOCK0) : ST_IDLE;
            last_d  = win_sel;
            addr_d  = win_addr;
            wdata_d = win_wdata;
            // Only a non-forced locked grant with the other port waiting
            // extends the streak; anything else restarts it.
            if (!force_ho && lock[win_sel] && req[~win_sel]) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = '0;
            end
        end else if (!locked || !req[other]) begin
            cnt_d = '0;
        end
    end

    // Outputs
    always_comb begin
        bus.gnt_0         = gnt[0];
        bus.gnt_1         = gnt[1];
        bus.mem_wr_enable = win_valid & we[win_sel];
        bus.mem_addr      = addr_q;
        bus.mem_wr_data   = wdata_q;
        if (reset) begin
            bus.mem_addr    = '0;
            bus.mem_wr_data = '0;
        end else if (win_valid) begin
            bus.mem_addr    = win_addr;
            bus.mem_wr_data = win_wdata;
        end
        // A read granted just before reset must not surface during reset.
        bus.rvalid_0 = rvalid_q[0] & ~reset;
        bus.rvalid_1 = rvalid_q[1] & ~reset;
        bus.rdata_0  = bus.mem_rd_data;
        bus.rdata_1  = bus.mem_rd_data;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter MAX_LOCK, default 7, maximum consecutive locked grants to one port while the other waits (range 1..255).
REQ-004 SHALL have one clock and a synchronous, active-high reset. Ports: clk, reset.
REQ-005 SHALL have ports (n = 0 core, n = 1 DMA/loader), each replicated per n:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_n  in  1  access request this cycle
- lock_n  in  1  keep ownership after this access (read-modify-write, vector fetch)
- we_n  in  1  1 = write, 0 = read
- addr_n  in  ADDR_W  access address
- wdata_n  in  DATA_W  write data
- gnt_n  out  1  access accepted this cycle
- rvalid_n  out  1  read data valid (one cycle after granted read)
- rdata_n  out  DATA_W  read data
- mem_addr  out  ADDR_W  memory address
- mem_wr_data  out  DATA_W  memory write data
- mem_wr_enable  out  1  memory write strobe
- mem_rd_data  in  DATA_W  memory read data, valid one cycle after mem_addr

Function
REQ-006 SHALL implement states IDLE, LOCK0 and LOCK1. LOCKn means port n owns the bus.
REQ-007 SHALL accept at most one access per cycle. gnt_0 and gnt_1 are never both high.
REQ-008 SHALL select the winner combinationally in the request cycle:
- if state is LOCKn, req_n = 1 and no forced handover, then port n wins;
- otherwise, if only one port requests, it wins;
- otherwise, the port != last_served wins.
REQ-009 SHALL raise gnt_n in the same cycle as req_n when port n wins (zero-cycle grant latency). A non-winning requester holds req/addr/we/wdata until granted.
REQ-010 SHALL drive mem_addr, mem_wr_data and mem_wr_enable combinationally from the winner.
- mem_wr_enable = winner we_n & gnt_n.
- With no grant: mem_addr holds its last granted value and mem_wr_enable = 0.
REQ-011 SHALL assert rvalid_n exactly one cycle after a granted read by port n, with rdata_n = mem_rd_data. No rvalid follows a granted write.
REQ-012 SHALL drive rdata_n = mem_rd_data at all times. Consumers qualify it with rvalid_n.
REQ-013 SHALL set next state on each grant:
- LOCKn if lock_n = 1 on that grant, else IDLE.
- last_served is updated to the winner.
REQ-014 SHALL leave state unchanged in LOCKn when port n does not request. The other port is blocked until port n issues a grant with lock_n = 0.
REQ-015 SHALL count, in an 8-bit lock_cnt, consecutive locked grants to the owner while the other port has req high.
- lock_cnt clears on any handover, on any grant with lock_n = 0, and in any cycle the other port is not requesting.
REQ-016 SHALL force a handover when lock_cnt = MAX_LOCK and the other port requests: the other port wins that cycle and state becomes LOCK of the new winner or IDLE.
REQ-017 SHALL, if both ports request in IDLE on the first cycle after reset, grant port 0 (last_served resets to 1).
REQ-018 SHALL have no address decode, no wait states and no write/read hazard handling. Memory is a single-port synchronous RAM.

Reset
REQ-019 SHALL on reset set the following:
- state = IDLE, last_served = 1, lock_cnt = 0;
- gnt_0 = gnt_1 = 0, rvalid_0 = rvalid_1 = 0, mem_wr_enable = 0, mem_addr = 0, mem_wr_data = 0.
REQ-020 SHALL discard a read granted in the cycle before reset asserts: no rvalid after reset.
REQ-021 SHALL ignore req inputs during the reset cycle (no grant while reset = 1).

Structure
REQ-022 SHALL place state encoding (IDLE/LOCK0/LOCK1) and port index constants in the shared processor include alongside the opcode/parameter includes.
REQ-023 SHALL be a single module. An optional sub-module arb_rr2 (two-input round-robin picker with last_served input) is permitted for the REQ-008 selection.

Verification
REQ-024 Port 0 reads 16'hFFFC, only requester: gnt_0 is high that cycle, mem_addr = FFFC, and rvalid_0 is high next cycle with rdata_0 = memory[FFFC].
REQ-025 Both ports request continuously with lock low from reset: grants alternate 0,1,0,1. Each rvalid follows its grant by 1 cycle.
REQ-026 Port 1 writes 8'hA5 to 16'h0200 while port 0 is idle: mem_wr_enable = 1, mem_addr = 0200, mem_wr_data = A5 in the grant cycle, and no rvalid_1 follows.
REQ-027 Port 0 locks (RMW on 16'h0010: read, then write with lock low) while port 1 requests: port 1 is granted only after port 0's unlocked write.
REQ-028 Port 0 holds lock and req high indefinitely, port 1 requests, MAX_LOCK = 7: port 1 is granted on the 8th cycle, then port 0 resumes.
REQ-029 Reset asserted the cycle after a granted read by port 1: rvalid_1 stays 0, state = IDLE, and the next simultaneous request is granted to port 0.
